// File: rtl/sorted_array_streamer.sv
// Captures a packed sorted array on a rise of array_valid and streams it out
// one element per valid/ready transfer, flagging unsorted input and lost captures.
module sorted_array_streamer #(
   parameter int ARR_WIDTH = 4,
   parameter int ELEM_W    = 4,
   parameter int IDX_W     = 2
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [ARR_WIDTH*ELEM_W-1:0] array_in,
   input  logic                        array_valid,
   output logic                        busy,
   output logic [ELEM_W-1:0]           elem_out,
   output logic [IDX_W-1:0]            elem_idx,
   output logic                        elem_valid,
   input  logic                        elem_ready,
   output logic                        elem_last,
   output logic                        done,
   output logic                        order_err,
   output logic                        overrun
);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                            state, state_nxt;
   logic [ARR_WIDTH-1:0][ELEM_W-1:0]  arr_buf;
   logic [IDX_W-1:0]                  idx;
   logic                              av_q;
   logic                              rise;
   logic                              xfer;
   logic                              at_last;
   logic                              unsorted;

   assign rise    = array_valid & ~av_q;
   assign at_last = (idx == IDX_W'(ARR_WIDTH-1));
   assign xfer    = elem_valid & elem_ready;

   // Every output is decoded from registered state only, so elem_ready never
   // reaches an output combinationally.
   assign elem_valid = (state == STREAM);
   assign busy       = elem_valid;
   assign elem_out   = elem_valid ? arr_buf[idx] : '0;
   assign elem_idx   = elem_valid ? idx : '0;
   assign elem_last  = elem_valid & at_last;

   always_comb begin
      unsorted = 1'b0;
      for (int i = 0; i < ARR_WIDTH-1; i++)
         if (array_in[i*ELEM_W +: ELEM_W] > array_in[(i+1)*ELEM_W +: ELEM_W])
            unsorted = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rise) state_nxt = STREAM;
         STREAM:  if (xfer && at_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         av_q      <= 1'b0;
         arr_buf   <= '0;
         idx       <= '0;
         done      <= 1'b0;
         order_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state <= state_nxt;
         av_q  <= array_valid;
         done  <= xfer & at_last;
         if (state == IDLE && rise) begin
            arr_buf   <= array_in;
            idx       <= '0;
            order_err <= unsorted;
         end else if (xfer && !at_last) begin
            idx <= idx + IDX_W'(1);
         end
         // A rise during a stream cannot be captured; remember it was lost.
         if (state == STREAM && rise)
            overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sorted_array_streamer.sv
// Directed, table-driven bench for sorted_array_streamer (ARR_WIDTH=4, ELEM_W=4).
module tb_sorted_array_streamer;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] array_in;
   logic        array_valid;
   logic        busy;
   logic [3:0]  elem_out;
   logic [1:0]  elem_idx;
   logic        elem_valid;
   logic        elem_ready;
   logic        elem_last;
   logic        done;
   logic        order_err;
   logic        overrun;

   int total = 0;
   int passed = 0;

   sorted_array_streamer #(.ARR_WIDTH(4), .ELEM_W(4), .IDX_W(2)) dut (
      .clock(clock), .reset(reset), .array_in(array_in), .array_valid(array_valid),
      .busy(busy), .elem_out(elem_out), .elem_idx(elem_idx), .elem_valid(elem_valid),
      .elem_ready(elem_ready), .elem_last(elem_last), .done(done),
      .order_err(order_err), .overrun(overrun)
   );

   always #5 clock = ~clock;

   // Inputs for the coming edge, then outputs expected just after it.
   typedef struct {
      logic [15:0] arr;
      bit          av;
      bit          rdy;
      bit          ev;
      int          eo;
      int          ei;
      bit          el;
      bit          dn;
      bit          oe;
   } vec_t;

   vec_t vecs[$];

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, " valid"}, int'(elem_valid), 0);
      chk({nm, " busy"},  int'(busy), 0);
      chk({nm, " elem"},  int'(elem_out), 0);
      chk({nm, " idx"},   int'(elem_idx), 0);
      chk({nm, " last"},  int'(elem_last), 0);
      chk({nm, " done"},  int'(done), 0);
   endtask

   initial begin
      int n_valid, n_done;

      // basic, sorted 9531 -> 1,3,5,9
      vecs.push_back(vec_t'{16'h9531, 1, 1, 1, 1, 0, 0, 0, 0});
      vecs.push_back(vec_t'{16'h9531, 1, 1, 1, 3, 1, 0, 0, 0});
      vecs.push_back(vec_t'{16'h9531, 1, 1, 1, 5, 2, 0, 0, 0});
      vecs.push_back(vec_t'{16'h9531, 0, 1, 1, 9, 3, 1, 0, 0});
      vecs.push_back(vec_t'{16'h9531, 0, 1, 0, 0, 0, 0, 1, 0});
      vecs.push_back(vec_t'{16'h9531, 0, 1, 0, 0, 0, 0, 0, 0});
      // backpressure 0,1,0,0,1,1,0,1; array_in scribbled mid-stream
      vecs.push_back(vec_t'{16'h9531, 1, 0, 1, 1, 0, 0, 0, 0});
      vecs.push_back(vec_t'{16'hFFFF, 1, 0, 1, 1, 0, 0, 0, 0});
      vecs.push_back(vec_t'{16'hFFFF, 0, 1, 1, 3, 1, 0, 0, 0});
      vecs.push_back(vec_t'{16'hFFFF, 0, 0, 1, 3, 1, 0, 0, 0});
      vecs.push_back(vec_t'{16'hFFFF, 0, 0, 1, 3, 1, 0, 0, 0});
      vecs.push_back(vec_t'{16'hFFFF, 0, 1, 1, 5, 2, 0, 0, 0});
      vecs.push_back(vec_t'{16'hFFFF, 0, 1, 1, 9, 3, 1, 0, 0});
      vecs.push_back(vec_t'{16'hFFFF, 0, 0, 1, 9, 3, 1, 0, 0});
      vecs.push_back(vec_t'{16'hFFFF, 0, 1, 0, 0, 0, 0, 1, 0});
      vecs.push_back(vec_t'{16'hFFFF, 0, 1, 0, 0, 0, 0, 0, 0});
      // unsorted 1359 -> 9,5,3,1, then back-to-back capture in the done cycle
      vecs.push_back(vec_t'{16'h1359, 1, 1, 1, 9, 0, 0, 0, 1});
      vecs.push_back(vec_t'{16'h1359, 1, 1, 1, 5, 1, 0, 0, 1});
      vecs.push_back(vec_t'{16'h1359, 0, 1, 1, 3, 2, 0, 0, 1});
      vecs.push_back(vec_t'{16'h1359, 0, 1, 1, 1, 3, 1, 0, 1});
      vecs.push_back(vec_t'{16'h9531, 0, 1, 0, 0, 0, 0, 1, 1});
      vecs.push_back(vec_t'{16'h9531, 1, 1, 1, 1, 0, 0, 0, 0});
      vecs.push_back(vec_t'{16'h9531, 1, 1, 1, 3, 1, 0, 0, 0});
      vecs.push_back(vec_t'{16'h9531, 0, 1, 1, 5, 2, 0, 0, 0});
      vecs.push_back(vec_t'{16'h9531, 0, 1, 1, 9, 3, 1, 0, 0});
      vecs.push_back(vec_t'{16'h9531, 0, 1, 0, 0, 0, 0, 1, 0});
      vecs.push_back(vec_t'{16'h9531, 0, 1, 0, 0, 0, 0, 0, 0});

      reset = 1'b1; array_in = 16'h0; array_valid = 1'b0; elem_ready = 1'b0;
      step();
      chk_idle("reset");
      chk("reset order_err", int'(order_err), 0);
      chk("reset overrun", int'(overrun), 0);
      reset = 1'b0;
      step();

      foreach (vecs[i]) begin
         array_in = vecs[i].arr; array_valid = vecs[i].av; elem_ready = vecs[i].rdy;
         step();
         chk($sformatf("v%0d valid", i), int'(elem_valid), int'(vecs[i].ev));
         chk($sformatf("v%0d busy", i),  int'(busy), int'(vecs[i].ev));
         chk($sformatf("v%0d elem", i),  int'(elem_out), vecs[i].eo);
         chk($sformatf("v%0d idx", i),   int'(elem_idx), vecs[i].ei);
         chk($sformatf("v%0d last", i),  int'(elem_last), int'(vecs[i].el));
         chk($sformatf("v%0d done", i),  int'(done), int'(vecs[i].dn));
         chk($sformatf("v%0d order_err", i), int'(order_err), int'(vecs[i].oe));
      end
      chk("table overrun", int'(overrun), 0);

      // level hold: one stream, one done over 20 high cycles
      array_in = 16'h9531; elem_ready = 1'b1; array_valid = 1'b1;
      n_valid = 0; n_done = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         n_valid += int'(elem_valid);
         n_done  += int'(done);
      end
      chk("hold transfers", n_valid, 4);
      chk("hold dones", n_done, 1);
      array_valid = 1'b0;
      step();
      array_valid = 1'b1;
      step();
      chk("rerise valid", int'(elem_valid), 1);
      chk("rerise elem", int'(elem_out), 1);
      array_valid = 1'b0;
      n_done = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         n_done += int'(done);
      end
      chk("rerise dones", n_done, 1);
      chk("rerise overrun", int'(overrun), 0);

      // overrun: fall at idx1, rise at idx2 edge
      array_valid = 1'b1;
      step();
      chk("ovr idx0", int'(elem_idx), 0);
      step();
      chk("ovr idx1", int'(elem_idx), 1);
      array_valid = 1'b0;
      step();
      chk("ovr idx2 elem", int'(elem_out), 5);
      chk("ovr flag before", int'(overrun), 0);
      array_valid = 1'b1;
      step();
      chk("ovr flag", int'(overrun), 1);
      chk("ovr idx3 elem", int'(elem_out), 9);
      chk("ovr idx3 last", int'(elem_last), 1);
      step();
      chk("ovr done", int'(done), 1);
      n_valid = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         n_valid += int'(elem_valid);
      end
      chk("ovr no second stream", n_valid, 0);
      chk("ovr sticky", int'(overrun), 1);

      // reset mid-stream after element 1 transferred
      array_valid = 1'b0;
      step();
      array_valid = 1'b1;
      step();
      step();
      step();
      chk("rst pre idx", int'(elem_idx), 2);
      reset = 1'b1; array_valid = 1'b0;
      step();
      chk_idle("rst");
      chk("rst overrun", int'(overrun), 0);
      reset = 1'b0;
      n_done = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         n_done += int'(done) + int'(elem_valid);
      end
      chk("rst no done", n_done, 0);
      array_in = 16'h8420; array_valid = 1'b1;
      step();
      chk("post rst elem0", int'(elem_out), 0);
      chk("post rst valid", int'(elem_valid), 1);
      step(); step();
      chk("post rst elem2", int'(elem_out), 4);
      step();
      chk("post rst elem3", int'(elem_out), 8);
      step();
      chk("post rst done", int'(done), 1);
      chk("post rst order_err", int'(order_err), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
